// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch-side PC sequencer.
package pc_sequencer_pkg;

  // Sequencer control states
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PEND = 2'd1,
    ST_HALT = 2'd2
  } seq_state_t;

  // Instruction size in bytes; sequential fetch step
  localparam int unsigned INSN_BYTES = 4;

  // Default first fetch address after reset
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_sequencer_sat_counter.sv
// Saturating up-counter with synchronous active-low clear; never wraps.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count up on inc, stick at all-ones once reached
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-side program-counter sequencer: forms branch_taken from the EX
// qualifiers, drives the fetch address handshake, generates IF/ID and
// ID/EX flushes and traps misaligned control-flow targets.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_branch_flag,
  input  logic             ex_is_jump,
  input  logic [31:0]      ex_target,
  input  logic             stall,
  input  logic             imem_ready,
  output logic             imem_req_valid,
  output logic [31:0]      imem_addr,
  output logic             flush_if,
  output logic             flush_id,
  output logic             misalign_trap,
  output logic [31:0]      misalign_addr,
  output logic [CNT_W-1:0] redirect_count
);

  seq_state_t  state;
  logic [31:0] pc;
  logic [31:0] pend_pc;
  logic        live;
  logic        take;
  logic        misalign;
  logic        redirect;
  logic        accept;

  // Take/flush decode; everything is gated off during reset and in HALT
  always_comb begin
    live           = rst_n && (state != ST_HALT);
    take           = live && ex_valid &&
                     (ex_is_jump || (ex_is_branch && ex_branch_flag));
    misalign       = take && (ex_target[1:0] != 2'b00);
    redirect       = take && !misalign;
    imem_req_valid = live;
    imem_addr      = pc;
    accept         = imem_req_valid && imem_ready;
    // In PEND the request being accepted is stale, so IF/ID must drop it
    flush_if       = take || (live && (state == ST_PEND) && accept);
    flush_id       = take;
  end

  // PC, pending target, state and trap registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_RUN;
      pc            <= RESET_PC;
      pend_pc       <= '0;
      misalign_addr <= '0;
      misalign_trap <= 1'b0;
    end else begin
      misalign_trap <= misalign;
      unique case (state)
        ST_RUN: begin
          if (misalign) begin
            state         <= ST_HALT;
            misalign_addr <= ex_target;
          end else if (redirect) begin
            // An outstanding request cannot be withdrawn, so park the
            // target until the current address is accepted
            if (accept) begin
              pc <= ex_target;
            end else begin
              pend_pc <= ex_target;
              state   <= ST_PEND;
            end
          end else if (accept && !stall) begin
            pc <= pc + INSN_BYTES;
          end
        end
        ST_PEND: begin
          if (misalign) begin
            state         <= ST_HALT;
            misalign_addr <= ex_target;
          end else if (redirect) begin
            // Youngest redirect wins over the parked one
            if (accept) begin
              pc    <= ex_target;
              state <= ST_RUN;
            end else begin
              pend_pc <= ex_target;
            end
          end else if (accept) begin
            pc    <= pend_pc;
            state <= ST_RUN;
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state <= ST_HALT;
        end
      endcase
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_redirect_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (redirect),
    .count (redirect_count)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer.
module tb_pc_sequencer;

  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             ex_valid;
  logic             ex_is_branch;
  logic             ex_branch_flag;
  logic             ex_is_jump;
  logic [31:0]      ex_target;
  logic             stall;
  logic             imem_ready;
  logic             imem_req_valid;
  logic [31:0]      imem_addr;
  logic             flush_if;
  logic             flush_id;
  logic             misalign_trap;
  logic [31:0]      misalign_addr;
  logic [CNT_W-1:0] redirect_count;

  int errors = 0;
  int checks = 0;

  pc_sequencer #(
    .RESET_PC (32'h0000_0100),
    .CNT_W    (CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_valid       (ex_valid),
    .ex_is_branch   (ex_is_branch),
    .ex_branch_flag (ex_branch_flag),
    .ex_is_jump     (ex_is_jump),
    .ex_target      (ex_target),
    .stall          (stall),
    .imem_ready     (imem_ready),
    .imem_req_valid (imem_req_valid),
    .imem_addr      (imem_addr),
    .flush_if       (flush_if),
    .flush_id       (flush_id),
    .misalign_trap  (misalign_trap),
    .misalign_addr  (misalign_addr),
    .redirect_count (redirect_count)
  );

  // Starts high so inputs applied at t=0 are checked before the first edge
  initial clk = 1'b1;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n, ev, br, fl, jp;
    logic [31:0] tgt;
    logic        st, rdy;
    logic        e_val;
    logic [31:0] e_addr;
    logic        e_fif, e_fid, e_trap;
    logic [31:0] e_cnt;
    logic [31:0] e_maddr;
    logic        chk_regs;
  } vec_t;

  function automatic vec_t v(
    input logic rs, ev, br, fl, jp, input logic [31:0] tgt,
    input logic st, rdy, e_val, input logic [31:0] e_addr,
    input logic e_fif, e_fid, e_trap, input logic [31:0] e_cnt,
    input logic [31:0] e_maddr, input logic chk);
    vec_t r;
    r.rst_n = rs; r.ev = ev; r.br = br; r.fl = fl; r.jp = jp; r.tgt = tgt;
    r.st = st; r.rdy = rdy; r.e_val = e_val; r.e_addr = e_addr;
    r.e_fif = e_fif; r.e_fid = e_fid; r.e_trap = e_trap; r.e_cnt = e_cnt;
    r.e_maddr = e_maddr; r.chk_regs = chk;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rs, ev, br, fl, jp, input logic [31:0] tgt,
                       input logic st, rdy);
    rst_n = rs; ex_valid = ev; ex_is_branch = br; ex_branch_flag = fl;
    ex_is_jump = jp; ex_target = tgt; stall = st; imem_ready = rdy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[24];

  initial begin
    //            rs ev br fl jp target         st rdy  val addr          fif fid trp cnt maddr         chk
    vecs[0]  = v(0, 0, 0, 0, 0, 32'h0,          0, 1,   0, 32'h0,          0, 0, 0, 0, 32'h0,          0);
    vecs[1]  = v(0, 0, 0, 0, 0, 32'h0,          0, 1,   0, 32'h100,        0, 0, 0, 0, 32'h0,          1);
    vecs[2]  = v(1, 0, 0, 0, 0, 32'h0,          0, 1,   1, 32'h100,        0, 0, 0, 0, 32'h0,          1);
    vecs[3]  = v(1, 0, 0, 0, 0, 32'h0,          0, 1,   1, 32'h104,        0, 0, 0, 0, 32'h0,          1);
    vecs[4]  = v(1, 1, 1, 1, 0, 32'h200,        0, 1,   1, 32'h108,        1, 1, 0, 0, 32'h0,          1);
    vecs[5]  = v(1, 1, 1, 0, 0, 32'h500,        0, 1,   1, 32'h200,        0, 0, 0, 1, 32'h0,          1);
    vecs[6]  = v(1, 1, 0, 1, 0, 32'h500,        0, 1,   1, 32'h204,        0, 0, 0, 1, 32'h0,          1);
    vecs[7]  = v(1, 0, 0, 0, 1, 32'h600,        0, 1,   1, 32'h208,        0, 0, 0, 1, 32'h0,          1);
    vecs[8]  = v(1, 0, 0, 0, 0, 32'h0,          0, 0,   1, 32'h20C,        0, 0, 0, 1, 32'h0,          1);
    vecs[9]  = v(1, 1, 0, 0, 1, 32'h300,        0, 0,   1, 32'h20C,        1, 1, 0, 1, 32'h0,          1);
    vecs[10] = v(1, 0, 0, 0, 0, 32'h0,          0, 0,   1, 32'h20C,        0, 0, 0, 2, 32'h0,          1);
    vecs[11] = v(1, 0, 0, 0, 0, 32'h0,          0, 1,   1, 32'h20C,        1, 0, 0, 2, 32'h0,          1);
    vecs[12] = v(1, 0, 0, 0, 0, 32'h0,          1, 1,   1, 32'h300,        0, 0, 0, 2, 32'h0,          1);
    vecs[13] = v(1, 1, 0, 0, 1, 32'h400,        1, 1,   1, 32'h300,        1, 1, 0, 2, 32'h0,          1);
    vecs[14] = v(1, 1, 0, 0, 1, 32'hFFFF_FFFC,  0, 1,   1, 32'h400,        1, 1, 0, 3, 32'h0,          1);
    vecs[15] = v(1, 0, 0, 0, 0, 32'h0,          0, 1,   1, 32'hFFFF_FFFC,  0, 0, 0, 4, 32'h0,          1);
    vecs[16] = v(1, 1, 0, 0, 1, 32'h700,        0, 0,   1, 32'h0,          1, 1, 0, 4, 32'h0,          1);
    vecs[17] = v(1, 1, 0, 0, 1, 32'h800,        0, 0,   1, 32'h0,          1, 1, 0, 5, 32'h0,          1);
    vecs[18] = v(1, 0, 0, 0, 0, 32'h0,          0, 1,   1, 32'h0,          1, 0, 0, 6, 32'h0,          1);
    vecs[19] = v(1, 1, 0, 0, 1, 32'h202,        0, 1,   1, 32'h800,        1, 1, 0, 6, 32'h0,          1);
    vecs[20] = v(1, 1, 0, 0, 1, 32'h300,        0, 1,   0, 32'h800,        0, 0, 1, 6, 32'h202,        1);
    vecs[21] = v(1, 1, 1, 1, 0, 32'h300,        0, 1,   0, 32'h800,        0, 0, 0, 6, 32'h202,        1);
    vecs[22] = v(0, 0, 0, 0, 0, 32'h0,          0, 1,   0, 32'h800,        0, 0, 0, 6, 32'h202,        1);
    vecs[23] = v(1, 0, 0, 0, 0, 32'h0,          0, 1,   1, 32'h100,        0, 0, 0, 0, 32'h0,          1);

    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].rst_n, vecs[i].ev, vecs[i].br, vecs[i].fl, vecs[i].jp,
            vecs[i].tgt, vecs[i].st, vecs[i].rdy);
      @(negedge clk);
      check($sformatf("v%0d.valid", i), 32'(imem_req_valid), 32'(vecs[i].e_val));
      check($sformatf("v%0d.flush_if", i), 32'(flush_if), 32'(vecs[i].e_fif));
      check($sformatf("v%0d.flush_id", i), 32'(flush_id), 32'(vecs[i].e_fid));
      if (vecs[i].chk_regs) begin
        check($sformatf("v%0d.addr", i), imem_addr, vecs[i].e_addr);
        check($sformatf("v%0d.trap", i), 32'(misalign_trap), 32'(vecs[i].e_trap));
        check($sformatf("v%0d.count", i), 32'(redirect_count), vecs[i].e_cnt);
        check($sformatf("v%0d.maddr", i), misalign_addr, vecs[i].e_maddr);
      end
      next_cycle();
    end

    // 20 back-to-back aligned jumps: counter must stop at 0xF
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 0, 0, 1, 32'h1000, 0, 1);
      @(negedge clk);
      check($sformatf("sat%0d.count", i), 32'(redirect_count), (i < 15) ? i : 15);
      next_cycle();
    end
    drive(1, 0, 0, 0, 0, 32'h0, 0, 1);
    @(negedge clk);
    check("sat.final_count", 32'(redirect_count), 32'hF);
    check("sat.addr", imem_addr, 32'h1000);
    next_cycle();

    // Reset while a redirect is parked must discard it
    drive(1, 1, 0, 0, 1, 32'h900, 0, 0);
    @(negedge clk);
    check("rstpend.addr", imem_addr, 32'h1004);
    check("rstpend.flush_if", 32'(flush_if), 32'h1);
    next_cycle();
    drive(0, 0, 0, 0, 0, 32'h0, 0, 1);
    @(negedge clk);
    check("rstpend.valid_in_reset", 32'(imem_req_valid), 32'h0);
    check("rstpend.flush_in_reset", 32'(flush_if), 32'h0);
    next_cycle();
    drive(1, 0, 0, 0, 0, 32'h0, 0, 1);
    @(negedge clk);
    check("rstpend.addr0", imem_addr, 32'h100);
    check("rstpend.flush_after", 32'(flush_if), 32'h0);
    check("rstpend.count", 32'(redirect_count), 32'h0);
    next_cycle();
    @(negedge clk);
    check("rstpend.addr1", imem_addr, 32'h104);
    next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-side program-counter sequencer for the 5-stage pipeline. It consumes the branch decision from execute (branch flag, B-type/jump qualifiers, target) and produces the fetch address stream to instruction memory over a valid/ready handshake. It also generates the IF/ID and ID/EX flushes and traps misaligned control-flow targets. It is the consumer end of the branch-condition interface: branch_taken is formed here, not in execute.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- CNT_W, 16, width of saturating redirect counter
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- ex_valid  in  1  EX stage holds a live instruction
- ex_is_branch  in  1  EX instruction is B-type
- ex_branch_flag  in  1  branch condition result from execute
- ex_is_jump  in  1  EX instruction is JAL/JALR (unconditional)
- ex_target  in  32  resolved control-flow target
- stall  in  1  hazard-unit stall; blocks PC advance
- imem_ready  in  1  instruction memory accepts request this cycle
- imem_req_valid  out  1  fetch request valid
- imem_addr  out  32  fetch address (equals current PC)
- flush_if  out  1  squash IF/ID capture this cycle
- flush_id  out  1  squash ID/EX capture this cycle
- misalign_trap  out  1  one-cycle pulse on misaligned taken target
- misalign_addr  out  32  offending target, held until reset
- redirect_count  out  CNT_W  saturating count of taken redirects

## Operation
- take = ex_valid & (ex_is_jump | (ex_is_branch & ex_branch_flag)); ex_branch_flag ignored unless ex_is_branch.
- misalign = take & (ex_target[1:0] != 2'b00).
- accept = imem_req_valid & imem_ready.
- States: RUN, PEND, HALT.
- RUN: take & !misalign & accept -> pc <= ex_target, stay RUN. take & !misalign & !accept -> latch pend_pc <= ex_target, go PEND (pc and imem_addr unchanged; handshake must not be broken). No take: accept & !stall -> pc <= pc + 4; otherwise hold.
- PEND: imem_addr = pc held stable until accept; on accept pc <= pend_pc, flush_if = 1 that cycle (stale fetch dropped), go RUN. A new valid take in PEND overwrites pend_pc (youngest wins) and asserts flushes.
- Any take (RUN or PEND, aligned or not): flush_if = flush_id = 1 combinationally the same cycle.
- misalign in RUN/PEND: no redirect; go HALT; misalign_trap = 1 next cycle only; misalign_addr <= ex_target.
- HALT: imem_req_valid = 0, inputs ignored, exit only via reset.
- redirect_count increments on every aligned take, saturates at all-ones, never wraps.
- Redirect overrides stall; stall never delays a redirect.
- pc + 4 wraps modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).

## Timing
- Reset (rst_n low at edge): pc = RESET_PC, state RUN, pend_pc = 0, misalign_addr = 0, redirect_count = 0, misalign_trap = 0. While rst_n low: imem_req_valid = 0, flush_if = flush_id = 0 (gated). First request at RESET_PC the first cycle rst_n is high.
- Reset mid-PEND or in HALT: discards pending target, restarts at RESET_PC.
- Redirect resolved in EX cycle N with accept: imem_addr = target in N+1 (2-cycle taken penalty).
- Sequential fetch: one address per accepted, unstalled cycle; zero bubbles at imem_ready = 1.
- Handshake: once imem_req_valid high, imem_addr stable until accept (except HALT entry, which drops valid).
- Stalled cycle with accept: the same address is re-requested next cycle (idempotent read).

## Structure
- Shared core package: state enum (RUN/PEND/HALT), INSN_BYTES = 4, RESET_PC default constant.
- One sub-module: sat_counter (CNT_W parameter, inc, synchronous active-low clear) for redirect_count.
- Flush and take logic combinational; pc, pend_pc, state, misalign regs sequential.

## Test plan
- RESET_PC = 0x100, imem_ready = 1, rst_n low 2 cycles -> valid low during reset, then addresses 0x100, 0x104, 0x108 on consecutive cycles.
- Taken branch at N: ex_valid = 1, is_branch = 1, flag = 1, target 0x200 -> flush_if = flush_id = 1 in N, imem_addr = 0x200 in N+1, redirect_count = 1; same with flag = 0 -> no flush, 0x10C next, count 0.
- imem_ready = 0 at addr 0x108, jump target 0x300 -> addr held 0x108, state PEND; ready raised -> flush_if = 1 that cycle, addr 0x300 next.
- Taken target 0x202 -> flushes in N, misalign_trap pulse in N+1 only, misalign_addr = 0x202, imem_req_valid = 0 until reset.
- stall = 1, ready = 1 -> addr held; stall = 1 with jump to 0x400 same cycle -> addr 0x400 next cycle.
- CNT_W = 4, 20 aligned taken redirects -> redirect_count = 0xF, no wrap; PC at 0xFFFF_FFFC advances to 0x0.
